// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the oversampling UART receiver.
//   - parity mode encodings (PARITY_NONE / PARITY_EVEN / PARITY_ODD)
//   - receiver state encoding rx_state_t
//   - frame_bits(): total line bits in one frame, start bit included
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

  // Start bit + data bits + optional parity bit + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity,
                                    input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: received-word bus from the UART receiver to its consumer.
//   DATA_R     last received word, held until the next frame completes
//   VALID      one-cycle strobe: DATA_R and the error flags were updated
//   PARITY_ERR parity mismatch on the last frame
//   FRAME_ERR  a stop bit sampled 0 on the last frame
//   BUSY       receiver is not idle
//   state_dbg  current receiver state, for observation only
// Handshake: VALID is a pure strobe with no ready/back-pressure. The consumer
// must capture DATA_R and the flags in the cycle VALID is high (they stay
// stable until the next VALID), and qualifies the word with the error flags.
interface uart_rx_os_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] DATA_R;
  logic                 VALID;
  logic                 PARITY_ERR;
  logic                 FRAME_ERR;
  logic                 BUSY;
  uart_pkg::rx_state_t  state_dbg;

  modport master (output DATA_R, VALID, PARITY_ERR, FRAME_ERR, BUSY, state_dbg);
  modport slave  (input  DATA_R, VALID, PARITY_ERR, FRAME_ERR, BUSY, state_dbg);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep flop chain bringing the asynchronous RX line
// into the OUT_CLK domain. Resets to 1 (line idle) so reset never looks like
// a start bit.
//   OUT_CLK  oversample clock
//   RST      synchronous reset, active-high
//   rx       asynchronous serial input
//   rx_s     synchronised line, rx delayed by SYNC_STAGES flops
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic OUT_CLK,
  input  logic RST,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge OUT_CLK) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: parametrised oversampling UART receiver.
// Detects a start bit on the synchronised line, confirms it at mid start bit,
// then samples every following bit once at its midpoint (tick counter wraps
// every OVERSAMPLE cycles). Data is LSB first, optional even/odd parity,
// one or two stop bits. At the final stop-bit sample the word and error flags
// are registered and VALID strobes for one cycle; the FSM returns to IDLE at
// that point, leaving half a bit to catch a back-to-back start bit.
//   OUT_CLK  oversample clock, OVERSAMPLE x baud
//   RST      synchronous reset, active-high
//   RX       asynchronous serial line, idle high
//   bus      received-word bus (DATA_R, VALID, PARITY_ERR, FRAME_ERR, BUSY,
//            state_dbg)
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         OUT_CLK,
  input  logic         RST,
  input  logic         RX,
  uart_rx_os_if.master bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic          HAS_PARITY = 1'(PARITY != PARITY_NONE);
  localparam logic          ODD_PARITY = 1'(PARITY == PARITY_ODD);

  logic rx_s;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .OUT_CLK (OUT_CLK),
    .RST     (RST),
    .rx      (RX),
    .rx_s    (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;      // data bit index, then stop bit index
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;
  logic                 done;

  logic [DATA_BITS-1:0] data_r_q;
  logic                 valid_q, parity_err_q, frame_err_q;

  always_ff @(posedge OUT_CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      armed_q      <= 1'b1;
      data_r_q     <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
      valid_q <= done;
      if (done) begin
        data_r_q     <= shift_d;
        parity_err_q <= perr_d;
        frame_err_q  <= ferr_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    // A line seen high re-arms start detection after a break.
    armed_d = armed_q | rx_s;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s && armed_q) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (tick_q == TICK_MID) begin
          if (rx_s) begin
            state_d = IDLE;          // glitch: start bit gone by mid-bit
          end else begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      DATA: begin
        if (tick_q == TICK_LAST) begin
          shift_d[bit_q] = rx_s;
          tick_d         = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = HAS_PARITY ? PAR : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      PAR: begin
        if (tick_q == TICK_LAST) begin
          perr_d  = HAS_PARITY & (rx_s ^ (^shift_q) ^ ODD_PARITY);
          tick_d  = '0;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          ferr_d = ferr_q | ~rx_s;
          if (bit_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = IDLE;
            bit_d   = '0;
            // Line still low at the last stop sample: treat as a break and
            // ignore it until it has gone high again.
            if (ferr_d && !rx_s) armed_d = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.DATA_R     = data_r_q;
  assign bus.VALID      = valid_q;
  assign bus.PARITY_ERR = parity_err_q;
  assign bus.FRAME_ERR  = frame_err_q;
  assign bus.BUSY       = (state_q != IDLE);
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: self-checking bench for uart_rx_os.
// Three receivers share one clock:
//   dut 0 (a): 8N1, OVERSAMPLE 16, 2 sync stages
//   dut 1 (b): 8 data, even parity, 2 stop, OVERSAMPLE 16, 3 sync stages
//   dut 2 (c): 5 data, odd parity, 1 stop, OVERSAMPLE 4, 2 sync stages
// Frames are described as a list of line bits; the reference model derives
// the expected word, flags and VALID cycle from that list.
module tb_uart_rx_os;

  localparam int CFG_DB   [3] = '{8, 8, 5};
  localparam int CFG_OS   [3] = '{16, 16, 4};
  localparam int CFG_PAR  [3] = '{0, 1, 2};
  localparam int CFG_SB   [3] = '{1, 2, 1};
  localparam int CFG_SYNC [3] = '{2, 3, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v = 3'b111;
  logic [2:0] rx_v  = 3'b111;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  uart_rx_os_if #(.DATA_BITS(8)) bus_a ();
  uart_rx_os_if #(.DATA_BITS(8)) bus_b ();
  uart_rx_os_if #(.DATA_BITS(5)) bus_c ();

  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1),
               .SYNC_STAGES(2)) dut_a (
    .OUT_CLK(clk), .RST(rst_v[0]), .RX(rx_v[0]), .bus(bus_a.master));
  uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2),
               .SYNC_STAGES(3)) dut_b (
    .OUT_CLK(clk), .RST(rst_v[1]), .RX(rx_v[1]), .bus(bus_b.master));
  uart_rx_os #(.DATA_BITS(5), .OVERSAMPLE(4), .PARITY(2), .STOP_BITS(1),
               .SYNC_STAGES(2)) dut_c (
    .OUT_CLK(clk), .RST(rst_v[2]), .RX(rx_v[2]), .bus(bus_c.master));

  logic [2:0] valid_v, perr_v, ferr_v, busy_v;
  logic [8:0] data_v [3];
  assign valid_v   = {bus_c.VALID, bus_b.VALID, bus_a.VALID};
  assign perr_v    = {bus_c.PARITY_ERR, bus_b.PARITY_ERR, bus_a.PARITY_ERR};
  assign ferr_v    = {bus_c.FRAME_ERR, bus_b.FRAME_ERR, bus_a.FRAME_ERR};
  assign busy_v    = {bus_c.BUSY, bus_b.BUSY, bus_a.BUSY};
  assign data_v[0] = {1'b0, bus_a.DATA_R};
  assign data_v[1] = {1'b0, bus_b.DATA_R};
  assign data_v[2] = {4'b0, bus_c.DATA_R};

  // ---------------- monitor ----------------
  typedef struct {
    int         dut;
    int         cyc;
    logic [8:0] data;
    logic [1:0] err;   // {perr, ferr}
  } ev_t;

  ev_t        ev_q[$];
  ev_t        mon_e;
  logic [2:0] busy_seen = '0;

  always @(negedge clk) begin
    busy_seen = busy_seen | busy_v;
    for (int i = 0; i < 3; i++) begin
      if (valid_v[i] === 1'b1) begin
        mon_e.dut  = i;
        mon_e.cyc  = cyc;
        mon_e.data = data_v[i];
        mon_e.err  = {perr_v[i], ferr_v[i]};
        ev_q.push_back(mon_e);
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [8:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [1:0] exp_err_q[$];
  logic [8:0] last_data [3] = '{9'h0, 9'h0, 9'h0};
  logic       frame_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Expected result of the line bits in frame_q sent from cycle 'start'.
  function automatic void model_expect(input int d, input int start);
    logic [8:0] dv = '0;
    logic       pe = 1'b0;
    logic       fe = 1'b0;
    int         hp = (CFG_PAR[d] != 0) ? 1 : 0;
    int         db = CFG_DB[d];
    for (int i = 0; i < db; i++) dv[i] = frame_q[1 + i];
    if (hp == 1)
      pe = ((($countones(dv) + int'(frame_q[1 + db])) % 2) != ((CFG_PAR[d] == 2) ? 1 : 0));
    for (int s = 0; s < CFG_SB[d]; s++)
      if (frame_q[1 + db + hp + s] == 1'b0) fe = 1'b1;
    exp_q.push_back(dv);
    exp_err_q.push_back({pe, fe});
    exp_cyc_q.push_back(start + CFG_SYNC[d] + CFG_OS[d] / 2
                        + (db + hp + CFG_SB[d]) * CFG_OS[d] + 1);
    last_data[d] = dv;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_sb();
    ev_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    exp_err_q.delete();
  endtask

  task automatic drive_level(input int d, input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      rx_v[d] = v;
    end
  endtask

  // bad_par flips the correct parity bit; stop_v[s] is stop bit s;
  // noise flips the last cycle of every data bit (far from mid-bit).
  task automatic send_frame(input int d, input logic [8:0] data, input logic bad_par,
                            input logic [1:0] stop_v, input bit noise);
    logic [8:0] dm;
    logic       v;
    int         start;
    int         os = CFG_OS[d];
    dm = data & ((9'h1 << CFG_DB[d]) - 9'h1);
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < CFG_DB[d]; i++) frame_q.push_back(dm[i]);
    if (CFG_PAR[d] != 0)
      frame_q.push_back(1'(($countones(dm) % 2) == 1) ^ 1'(CFG_PAR[d] == 2) ^ bad_par);
    for (int s = 0; s < CFG_SB[d]; s++) frame_q.push_back(stop_v[s]);
    @(negedge clk);
    start = cyc;
    model_expect(d, start);
    for (int j = 0; j < frame_q.size(); j++) begin
      for (int k = 0; k < os; k++) begin
        if (j != 0 || k != 0) @(negedge clk);
        v = frame_q[j];
        if (noise && j >= 1 && j <= CFG_DB[d] && k == os - 1) v = ~v;
        rx_v[d] = v;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_v = 3'b111;
    rx_v  = 3'b111;
    repeat (3) @(negedge clk);
    rst_v = 3'b000;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks += 5;
      if (valid_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut%0d: got %b want 0", d, valid_v[d]); end
      if (busy_v[d]  !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy_v[d]); end
      if (perr_v[d]  !== 1'b0) begin n_fail++; $display("FAIL reset_perr dut%0d: got %b want 0", d, perr_v[d]); end
      if (ferr_v[d]  !== 1'b0) begin n_fail++; $display("FAIL reset_ferr dut%0d: got %b want 0", d, ferr_v[d]); end
      if (data_v[d]  !== 9'h0) begin n_fail++; $display("FAIL reset_data dut%0d: got %h want 0", d, data_v[d]); end
    end
  endtask

  task automatic test_basic();
    clear_sb();
    drive_level(0, 1'b1, 20);
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b0);
    drive_level(0, 1'b1, $urandom_range(0, 2) * 16);
    for (int n = 0; n < 6; n++) begin
      send_frame(0, 9'($urandom_range(0, 255)), 1'b0, 2'b11, 1'($urandom_range(0, 1)));
      drive_level(0, 1'b1, $urandom_range(0, 2) * 16);
    end
    drive_level(0, 1'b1, 40);
    n_checks++;
    if (ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", ev_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks += 4;
      if (ev_q[i].dut  != 0)            begin n_fail++; $display("FAIL basic_dut[%0d]: got %0d want 0", i, ev_q[i].dut); end
      if (ev_q[i].data !== exp_q[i])    begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, ev_q[i].data, exp_q[i]); end
      if (ev_q[i].err  !== exp_err_q[i]) begin n_fail++; $display("FAIL basic_err[%0d]: got %b want %b", i, ev_q[i].err, exp_err_q[i]); end
      if (ev_q[i].cyc  != exp_cyc_q[i]) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, ev_q[i].cyc, exp_cyc_q[i]); end
    end
  endtask

  task automatic test_parity();
    logic [1:0] st;
    logic       bad;
    for (int d = 1; d < 3; d++) begin
      clear_sb();
      drive_level(d, 1'b1, 10);
      if (d == 1) begin
        send_frame(1, 9'h037, 1'b0, 2'b11, 1'b0);   // parity bit 1: good
        drive_level(1, 1'b1, 16);
        send_frame(1, 9'h037, 1'b1, 2'b11, 1'b0);   // parity bit 0: error
        drive_level(1, 1'b1, 16);
      end
      for (int n = 0; n < 6; n++) begin
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        send_frame(d, 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), st,
                   1'($urandom_range(0, 1)));
        bad = (CFG_SB[d] == 2) ? (st != 2'b11) : ~st[0];
        drive_level(d, 1'b1, CFG_OS[d] * (bad ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2)));
      end
      drive_level(d, 1'b1, 2 * CFG_OS[d] + 8);
      n_checks++;
      if (ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL parity_count dut%0d: got %0d want %0d", d, ev_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
        n_checks += 4;
        if (ev_q[i].dut  != d)             begin n_fail++; $display("FAIL parity_dut[%0d]: got %0d want %0d", i, ev_q[i].dut, d); end
        if (ev_q[i].data !== exp_q[i])     begin n_fail++; $display("FAIL parity_data dut%0d[%0d]: got %h want %h", d, i, ev_q[i].data, exp_q[i]); end
        if (ev_q[i].err  !== exp_err_q[i]) begin n_fail++; $display("FAIL parity_err dut%0d[%0d]: got %b want %b", d, i, ev_q[i].err, exp_err_q[i]); end
        if (ev_q[i].cyc  != exp_cyc_q[i])  begin n_fail++; $display("FAIL parity_latency dut%0d[%0d]: got %0d want %0d", d, i, ev_q[i].cyc, exp_cyc_q[i]); end
      end
    end
  endtask

  task automatic test_false_start();
    int lens [3] = '{4, 7, 1};
    int duts [3] = '{0, 0, 2};
    int d;
    for (int t = 0; t < 3; t++) begin
      d = duts[t];
      clear_sb();
      drive_level(d, 1'b1, 10);
      busy_seen = '0;
      drive_level(d, 1'b0, lens[t]);
      drive_level(d, 1'b1, 40);
      n_checks += 3;
      if (busy_seen[d] !== 1'b1) begin n_fail++; $display("FAIL glitch_busy dut%0d len%0d: got %b want 1", d, lens[t], busy_seen[d]); end
      if (ev_q.size() != 0) begin n_fail++; $display("FAIL glitch_valid dut%0d len%0d: got %0d want 0", d, lens[t], ev_q.size()); end
      if (data_v[d] !== last_data[d]) begin n_fail++; $display("FAIL glitch_data dut%0d: got %h want %h", d, data_v[d], last_data[d]); end
    end
  endtask

  task automatic test_break();
    int start;
    clear_sb();
    drive_level(0, 1'b1, 10);
    frame_q.delete();
    for (int i = 0; i < 10; i++) frame_q.push_back(1'b0);
    @(negedge clk);
    start = cyc;
    rx_v[0] = 1'b0;
    model_expect(0, start);
    drive_level(0, 1'b0, 20 * 16 - 1);
    drive_level(0, 1'b1, 16);
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1'b0);
    drive_level(0, 1'b1, 40);
    n_checks++;
    if (ev_q.size() != 2) begin n_fail++; $display("FAIL break_count: got %0d want 2", ev_q.size()); end
    for (int i = 0; i < 2 && i < ev_q.size(); i++) begin
      n_checks += 3;
      if (ev_q[i].data !== exp_q[i])     begin n_fail++; $display("FAIL break_data[%0d]: got %h want %h", i, ev_q[i].data, exp_q[i]); end
      if (ev_q[i].err  !== exp_err_q[i]) begin n_fail++; $display("FAIL break_err[%0d]: got %b want %b", i, ev_q[i].err, exp_err_q[i]); end
      if (ev_q[i].cyc  != exp_cyc_q[i])  begin n_fail++; $display("FAIL break_latency[%0d]: got %0d want %0d", i, ev_q[i].cyc, exp_cyc_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_sb();
    drive_level(0, 1'b1, 10);
    send_frame(0, 9'h000, 1'b0, 2'b11, 1'b0);
    send_frame(0, 9'h0FF, 1'b0, 2'b11, 1'b0);
    drive_level(0, 1'b1, 40);
    n_checks++;
    if (ev_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", ev_q.size()); end
    if (ev_q.size() == 2) begin
      n_checks++;
      if (ev_q[1].cyc - ev_q[0].cyc < 160) begin n_fail++; $display("FAIL b2b_spacing: got %0d want >=160", ev_q[1].cyc - ev_q[0].cyc); end
    end
    for (int i = 0; i < 2 && i < ev_q.size(); i++) begin
      n_checks += 3;
      if (ev_q[i].data !== exp_q[i])     begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, ev_q[i].data, exp_q[i]); end
      if (ev_q[i].err  !== exp_err_q[i]) begin n_fail++; $display("FAIL b2b_err[%0d]: got %b want %b", i, ev_q[i].err, exp_err_q[i]); end
      if (ev_q[i].cyc  != exp_cyc_q[i])  begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, ev_q[i].cyc, exp_cyc_q[i]); end
    end
    // Two stop bits, second one 0.
    clear_sb();
    drive_level(1, 1'b1, 10);
    send_frame(1, 9'h096, 1'b0, 2'b01, 1'b0);
    drive_level(1, 1'b1, 32);
    send_frame(1, 9'h042, 1'b0, 2'b11, 1'b0);
    drive_level(1, 1'b1, 40);
    n_checks++;
    if (ev_q.size() != 2) begin n_fail++; $display("FAIL stop2_count: got %0d want 2", ev_q.size()); end
    for (int i = 0; i < 2 && i < ev_q.size(); i++) begin
      n_checks += 3;
      if (ev_q[i].data !== exp_q[i])     begin n_fail++; $display("FAIL stop2_data[%0d]: got %h want %h", i, ev_q[i].data, exp_q[i]); end
      if (ev_q[i].err  !== exp_err_q[i]) begin n_fail++; $display("FAIL stop2_err[%0d]: got %b want %b", i, ev_q[i].err, exp_err_q[i]); end
      if (ev_q[i].cyc  != exp_cyc_q[i])  begin n_fail++; $display("FAIL stop2_latency[%0d]: got %0d want %0d", i, ev_q[i].cyc, exp_cyc_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_sb();
    drive_level(0, 1'b1, 10);
    // 0x81 up to the middle of data bit 4: start, bit0=1, bits1..3=0, half of bit4.
    drive_level(0, 1'b0, 16);
    drive_level(0, 1'b1, 16);
    drive_level(0, 1'b0, 3 * 16 + 8);
    @(negedge clk);
    rst_v[0] = 1'b1;
    rx_v[0]  = 1'b1;
    @(negedge clk);
    n_checks += 5;
    if (busy_v[0]  !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_v[0]); end
    if (valid_v[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", valid_v[0]); end
    if (data_v[0]  !== 9'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 0", data_v[0]); end
    if (perr_v[0]  !== 1'b0) begin n_fail++; $display("FAIL rstmid_perr: got %b want 0", perr_v[0]); end
    if (ferr_v[0]  !== 1'b0) begin n_fail++; $display("FAIL rstmid_ferr: got %b want 0", ferr_v[0]); end
    rst_v[0]     = 1'b0;
    last_data[0] = 9'h0;
    drive_level(0, 1'b1, 40);
    n_checks++;
    if (ev_q.size() != 0) begin n_fail++; $display("FAIL rstmid_novalid: got %0d want 0", ev_q.size()); end
    clear_sb();
    send_frame(0, 9'h081, 1'b0, 2'b11, 1'b0);
    drive_level(0, 1'b1, 40);
    n_checks++;
    if (ev_q.size() != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", ev_q.size()); end
    if (ev_q.size() >= 1) begin
      n_checks += 3;
      if (ev_q[0].data !== exp_q[0])     begin n_fail++; $display("FAIL rstmid_data2: got %h want %h", ev_q[0].data, exp_q[0]); end
      if (ev_q[0].err  !== exp_err_q[0]) begin n_fail++; $display("FAIL rstmid_err2: got %b want %b", ev_q[0].err, exp_err_q[0]); end
      if (ev_q[0].cyc  != exp_cyc_q[0])  begin n_fail++; $display("FAIL rstmid_latency2: got %0d want %0d", ev_q[0].cyc, exp_cyc_q[0]); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_false_start();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver; successor to the fixed 8-bit, 9600-baud receiver.
- Clocked by OUT_CLK from the clock divider, which now runs at OVERSAMPLE × baud.
- Synchronises RX, validates the start bit and samples each bit at mid-bit.
- Supports configurable data width, parity and stop bits.
- Reports framing and parity errors with a one-cycle VALID strobe to downstream logic.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
OVERSAMPLE, 16, OUT_CLK cycles per bit (even, ≥4)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked (1 or 2)
SYNC_STAGES, 2, RX synchroniser flops (≥2)

Ports:
OUT_CLK  input  1  oversample clock, OVERSAMPLE × baud
RST  input  1  synchronous reset, active-high
RX  input  1  asynchronous serial line, idle high
DATA_R  output  DATA_BITS  last received word, held until next frame completes
VALID  output  1  one-cycle strobe: DATA_R and error flags updated
PARITY_ERR  output  1  parity mismatch on last frame (0 when PARITY=0)
FRAME_ERR  output  1  a stop bit sampled 0 on last frame
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset: RST is synchronous, active-high, on OUT_CLK.
  - Synchroniser flops are set to 1; state goes to IDLE; counters go to 0.
  - DATA_R=0, VALID=0, PARITY_ERR=0, FRAME_ERR=0, BUSY=0.
  - RST mid-frame aborts the frame with no VALID.
- rx_s is RX delayed by SYNC_STAGES flops. All decisions below use rx_s.
- tick counter: 0..OVERSAMPLE-1. bit counter: 0..DATA_BITS-1.
- IDLE: when rx_s=0 and armed=1, go to START and clear tick.
  - armed is cleared on entering FRAME_ERR-with-rx_s=0 (break).
  - armed is set while rx_s=1.
- START: at tick=OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s=1: false start, return to IDLE with no outputs changed.
  - rx_s=0: go to DATA, clear tick and bit counter.
- DATA: at tick=OVERSAMPLE-1, shift rx_s into the shift register at bit index bit counter (LSB first).
  - After bit DATA_BITS-1, go to PAR if PARITY≠0, else STOP.
- PAR: at tick=OVERSAMPLE-1, perr = rx_s XOR (XOR of data) XOR (PARITY==2).
- STOP: at tick=OVERSAMPLE-1, sample the stop bit; any 0 sets ferr.
  - If STOP_BITS=2, a second stop period follows.
  - At the final stop mid-sample:
    - Next cycle, DATA_R←shift register, PARITY_ERR←perr, FRAME_ERR←ferr, VALID=1 for exactly one cycle.
    - Go to IDLE immediately. This gives half a bit of resync margin, so back-to-back frames are received.
- VALID is asserted even when errors are present. Consumers qualify it with the flags.
- Latency: VALID rises (OVERSAMPLE/2) + (DATA_BITS + (PARITY≠0) + STOP_BITS) × OVERSAMPLE + 1 cycles after the first cycle rx_s=0.
- Break (RX held low): one frame completes with FRAME_ERR=1. No re-trigger until rx_s has returned high (armed).
- A glitch shorter than OVERSAMPLE/2 cycles is rejected as a false start.
- RX changes mid-bit away from the sample point are ignored. Single-sample (no majority vote) is decided.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD localparams;
  - rx state encoding IDLE, START, DATA, PAR, STOP;
  - a function computing frame length in bits.
- One sub-module, uart_rx_sync: an SYNC_STAGES-deep synchroniser that resets to 1 and outputs rx_s.
- Tick/bit counters and FSM stay in uart_rx_os.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 → one VALID, DATA_R=0xA5, both errors 0, VALID at cycle 8+9×16+1=153 after first rx_s=0.
- PARITY=1 (even), send 0x37 with parity bit 1 → PARITY_ERR=0. Same byte with parity bit 0 → PARITY_ERR=1, DATA_R=0x37.
- RX low for 4 cycles then high → BUSY pulses, no VALID, DATA_R unchanged.
- RX held low for 20 bit-times → exactly one VALID with DATA_R=0x00, FRAME_ERR=1. Then RX high for 1 bit and send 0x3C → VALID, DATA_R=0x3C, FRAME_ERR=0.
- Back-to-back 0x00 then 0xFF, single stop bit, no idle gap → two VALIDs ≥160 cycles apart with correct data. STOP_BITS=2 with second stop bit 0 → FRAME_ERR=1.
- Assert RST during DATA bit 4 → next cycle BUSY=0, all outputs 0, no VALID. Subsequent 0x81 is received correctly.
